// File: rtl/note_recorder.sv
// Purpose: capture a sequence of note codes into a register-file note RAM and hand it to playback.
// Latency: one cycle; a note pulse is visible in note_RAM/i_note/full after the capturing edge.
// Backpressure: none; notes arriving while full are silently dropped, write_en follows PLAY.
module note_recorder #(
  parameter int DEPTH  = 40,
  parameter int NOTE_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_rec,
  input  logic              start_play,
  input  logic              stop,
  input  logic              note_valid,
  input  logic [NOTE_W-1:0] note_in,
  output logic [NOTE_W-1:0] note_RAM [DEPTH-1:0],
  output logic [5:0]        i_note,
  output logic              write_en,
  output logic              full,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RECORD = 2'b01,
    PLAY   = 2'b10
  } state_t;

  // Count is 6 bits wide, so DEPTH must stay at or below 63.
  localparam logic [5:0] DEPTH_CNT = 6'(DEPTH);

  state_t     cur_state;
  state_t     nxt_state;
  logic [5:0] cnt_nxt;
  logic       clr_cnt;
  logic       wr_note;

  assign state = cur_state;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state and datapath controls; stop outranks both start pulses, but a
  // note arriving with stop while recording is still kept.
  always_comb begin
    nxt_state = cur_state;
    clr_cnt   = 1'b0;
    wr_note   = 1'b0;
    unique case (cur_state)
      IDLE: begin
        if (stop) begin
          nxt_state = IDLE;
        end else if (start_rec) begin
          nxt_state = RECORD;
          clr_cnt   = 1'b1;
        end else if (start_play && (i_note != 6'd0)) begin
          nxt_state = PLAY;
        end
      end
      RECORD: begin
        if (stop) begin
          nxt_state = IDLE;
          wr_note   = note_valid && !full;
        end else if (start_rec) begin
          // Restart the take; a note in the same cycle belongs to no take.
          clr_cnt   = 1'b1;
        end else begin
          wr_note   = note_valid && !full;
        end
      end
      PLAY: begin
        if (stop) begin
          nxt_state = IDLE;
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // Next note count; increments only on an accepted write so it never wraps.
  always_comb begin
    cnt_nxt = i_note;
    if (clr_cnt) begin
      cnt_nxt = 6'd0;
    end else if (wr_note) begin
      cnt_nxt = i_note + 6'd1;
    end
  end

  // Count, full flag and play enable, all registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_note   <= 6'd0;
      full     <= 1'b0;
      write_en <= 1'b0;
    end else begin
      i_note   <= cnt_nxt;
      full     <= (cnt_nxt == DEPTH_CNT);
      write_en <= (nxt_state == PLAY);
    end
  end

  // Note RAM: one write port at the current count, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        note_RAM[i] <= '0;
      end
    end else if (wr_note) begin
      note_RAM[i_note] <= note_in;
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Purpose: directed scoreboard bench for note_recorder.
// Latency: expectations are queued with each stimulus cycle and checked 1 ns after the edge.
// Backpressure: none; every step drains the scoreboard before the next one.
module tb_note_recorder;
  localparam int DEPTH  = 40;
  localparam int NOTE_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start_rec = 1'b0;
  logic              start_play = 1'b0;
  logic              stop = 1'b0;
  logic              note_valid = 1'b0;
  logic [NOTE_W-1:0] note_in = '0;
  logic [NOTE_W-1:0] note_RAM [DEPTH-1:0];
  logic [5:0]        i_note;
  logic              write_en;
  logic              full;
  logic [1:0]        state;

  note_recorder #(.DEPTH(DEPTH), .NOTE_W(NOTE_W)) dut (
    .clk(clk), .reset(reset), .start_rec(start_rec), .start_play(start_play),
    .stop(stop), .note_valid(note_valid), .note_in(note_in), .note_RAM(note_RAM),
    .i_note(i_note), .write_en(write_en), .full(full), .state(state)
  );

  always #5 clk = ~clk;

  // Scoreboard entries: kind 0 state, 1 i_note, 2 write_en, 3 full, 4 note_RAM[idx].
  typedef struct {
    string tag;
    int    kind;
    int    idx;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of the recorder.
  int m_state = 0;
  int m_cnt   = 0;
  int m_ram [DEPTH];

  function automatic int observe(int kind, int idx);
    case (kind)
      0: return int'(state);
      1: return int'(i_note);
      2: return int'(write_en);
      3: return int'(full);
      default: return int'(note_RAM[idx]);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int kind, input int idx, input int val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_model(input string tag);
    expect_val({tag, ".state"}, 0, 0, m_state);
    expect_val({tag, ".i_note"}, 1, 0, m_cnt);
    expect_val({tag, ".write_en"}, 2, 0, (m_state == 2) ? 1 : 0);
    expect_val({tag, ".full"}, 3, 0, (m_cnt == DEPTH) ? 1 : 0);
  endtask

  task automatic expect_ram(input string tag);
    for (int i = 0; i < DEPTH; i++) expect_val($sformatf("%s.ram%0d", tag, i), 4, i, m_ram[i]);
  endtask

  task automatic drain();
    exp_t e;
    int   obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind, e.idx);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    for (int i = 0; i < DEPTH; i++) m_ram[i] = 0;
  endtask

  task automatic model_step(input bit sr, input bit sp, input bit st, input bit nv, input int ni);
    case (m_state)
      0: begin
        if (st) m_state = 0;
        else if (sr) begin m_state = 1; m_cnt = 0; end
        else if (sp && m_cnt != 0) m_state = 2;
      end
      1: begin
        if (st) begin
          if (nv && m_cnt < DEPTH) begin m_ram[m_cnt] = ni; m_cnt++; end
          m_state = 0;
        end else if (sr) m_cnt = 0;
        else if (nv && m_cnt < DEPTH) begin m_ram[m_cnt] = ni; m_cnt++; end
      end
      default: if (st) m_state = 0;
    endcase
  endtask

  // One clock cycle with the given pulses; inputs are driven 1 ns after an edge.
  task automatic step(input string tag, input bit sr, input bit sp, input bit st,
                      input bit nv, input int ni, input bit chk_ram);
    start_rec = sr; start_play = sp; stop = st; note_valid = nv; note_in = NOTE_W'(ni);
    model_step(sr, sp, st, nv, ni);
    expect_model(tag);
    if (chk_ram) expect_ram(tag);
    @(posedge clk);
    #1;
    start_rec = 0; start_play = 0; stop = 0; note_valid = 0; note_in = '0;
    drain();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_ram[i] = 0;

    // Reset state.
    @(posedge clk); #1;
    reset = 1; #2;
    model_reset();
    expect_model("rst"); expect_ram("rst"); drain();
    @(posedge clk); #1; reset = 0;

    // Record five notes 0..4, then stop.
    step("rec_start", 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step($sformatf("rec%0d", k), 0, 0, 0, 1, k, 0);
    step("rec_stop", 0, 0, 1, 0, 0, 1);
    for (int k = 0; k < 5; k++) expect_val($sformatf("five.ram%0d", k), 4, k, k);
    expect_val("five.cnt", 1, 0, 5);
    expect_val("five.state", 0, 0, 0);
    drain();

    // Playback: enable held, RAM frozen against note_valid, stop drops enable.
    step("play_start", 0, 1, 0, 0, 0, 0);
    expect_val("play.we_first", 2, 0, 1); drain();
    for (int c = 0; c < 100; c++)
      step($sformatf("play%0d", c), c == 50 ? 1'b1 : 1'b0, c == 60 ? 1'b1 : 1'b0, 0,
           c == 10 ? 1'b1 : 1'b0, 9, c == 11 ? 1'b1 : 1'b0);
    expect_val("play.ram5", 4, 5, 0);
    expect_val("play.cnt", 1, 0, 5);
    drain();
    step("play_stop", 0, 0, 1, 0, 0, 0);
    expect_val("play.we_off", 2, 0, 0); drain();

    // Fill to DEPTH plus one dropped note.
    step("fill_start", 1, 0, 0, 0, 0, 0);
    for (int k = 0; k <= DEPTH; k++) step($sformatf("fill%0d", k), 0, 0, 0, 1, k, 0);
    expect_val("fill.cnt", 1, 0, 40);
    expect_val("fill.full", 3, 0, 1);
    expect_val("fill.ram39", 4, 39, 39);
    expect_val("fill.ram0", 4, 0, 0);
    drain();
    step("fill_hold", 0, 1, 0, 1, 5, 1);
    step("fill_stop", 0, 0, 1, 1, 7, 0);

    // Reset, empty play ignored, start_rec beats start_play.
    @(posedge clk); #1;
    reset = 1; #1; model_reset(); drain();
    @(posedge clk); #1; reset = 0;
    step("empty_play", 0, 1, 0, 0, 0, 0);
    expect_val("empty_play.state", 0, 0, 0);
    expect_val("empty_play.we", 2, 0, 0);
    drain();
    step("rec_vs_play", 1, 1, 0, 0, 0, 0);
    expect_val("rec_vs_play.state", 0, 0, 1); drain();

    // Restart drops same-cycle note; stop with start_rec goes IDLE.
    step("pre_a", 0, 0, 0, 1, 33, 0);
    step("restart", 1, 0, 0, 1, 44, 0);
    expect_val("restart.cnt", 1, 0, 0); drain();

    // Three notes, then stop together with note 17.
    for (int k = 0; k < 3; k++) step($sformatf("s%0d", k), 0, 0, 0, 1, 20 + k, 0);
    step("stop_note", 0, 0, 1, 1, 17, 1);
    expect_val("stop_note.ram3", 4, 3, 17);
    expect_val("stop_note.cnt", 1, 0, 4);
    expect_val("stop_note.state", 0, 0, 0);
    drain();
    step("idle_note", 0, 0, 1, 1, 50, 0);
    step("stop_vs_rec", 1, 0, 1, 0, 0, 0);
    expect_val("stop_vs_rec.state", 0, 0, 0); drain();

    // Reset in the middle of PLAY takes effect without a clock edge.
    step("play2", 0, 1, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) step($sformatf("play2_%0d", c), 0, 0, 0, 0, 0, 0);
    @(posedge clk); #3;
    reset = 1; #1;
    model_reset();
    expect_val("arst.we", 2, 0, 0);
    expect_val("arst.cnt", 1, 0, 0);
    expect_val("arst.full", 3, 0, 0);
    expect_val("arst.state", 0, 0, 0);
    expect_ram("arst");
    drain();
    @(posedge clk); #1; reset = 0;
    step("post_rec", 1, 0, 0, 0, 0, 0);
    step("post_n0", 0, 0, 0, 1, 63, 0);
    step("post_n1", 0, 0, 0, 1, 8, 1);
    expect_val("post.ram0", 4, 0, 63);
    expect_val("post.cnt", 1, 0, 2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
- Upstream capture stage for decoder_audio_playback.
- Records a sequence of 6-bit note codes from the note-entry front end (keys/switches, already debounced to one-cycle pulses) into a DEPTH-entry register-file note RAM.
- Drives the note RAM contents, the note count (i_note) and the play enable (write_en) that the playback stage consumes.
- A small IDLE/RECORD/PLAY state machine arbitrates between recording and playback.

Parameters:
- DEPTH, 40, number of note slots; must be <= 63 so the count fits in 6 bits.
- NOTE_W, 6, width of one note code.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_rec  input  1  one-cycle pulse: begin a new recording.
- start_play  input  1  one-cycle pulse: begin playback of the recorded sequence.
- stop  input  1  one-cycle pulse: end recording or playback and return to IDLE.
- note_valid  input  1  one-cycle pulse: note_in holds a new note to store.
- note_in  input  NOTE_W  note code, stored verbatim (0..63).
- note_RAM  output  NOTE_W x DEPTH (unpacked [DEPTH-1:0])  recorded notes, index 0 = first note.
- i_note  output  6  number of valid notes in note_RAM.
- write_en  output  1  play enable to decoder_audio_playback.
- full  output  1  high when i_note == DEPTH.
- state  output  2  current state: 00 IDLE, 01 RECORD, 10 PLAY.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, any state):
  - state = IDLE, i_note = 0, write_en = 0, full = 0.
  - Every note_RAM entry = 0.
  - Applies mid-RECORD or mid-PLAY with no further effect; write_en drops without waiting for a clock edge.
- IDLE:
  - start_rec -> RECORD; i_note cleared to 0 on the same edge. Old note_RAM contents remain but count as invalid.
  - start_play with i_note != 0 -> PLAY.
  - start_play with i_note == 0 is ignored; stay in IDLE.
  - start_rec and start_play in the same cycle: start_rec wins.
  - note_valid and stop are ignored.
- RECORD:
  - note_valid with i_note < DEPTH: note_RAM[i_note] <= note_in and i_note <= i_note + 1 on the same edge.
  - note_valid while full: dropped; note_RAM and i_note unchanged. Stay in RECORD until stop.
  - full is updated on the same edge as i_note, so full = 1 the cycle after the DEPTH-th write.
  - stop -> IDLE. A note_valid in the same cycle as stop is still captured if not full.
  - start_rec while already recording restarts the take: i_note <= 0 and any same-cycle note_valid is discarded.
  - start_play is ignored.
- PLAY:
  - write_en = 1 from the first cycle state == PLAY, i.e. one cycle after the start_play edge. It stays 1 throughout PLAY.
  - note_RAM and i_note are frozen; note_valid, start_rec and start_play are ignored.
  - stop -> IDLE; write_en = 0 on the same edge the state leaves PLAY.
- Invariant: write_en == (state == PLAY) at all times.
- Invariant: i_note <= DEPTH and never wraps.
- full is a pure function of the registered i_note (i_note == DEPTH), refreshed each edge.
- Simultaneous stop with start_rec or start_play in any state: stop wins, next state = IDLE. Exception: in RECORD, a same-cycle note_valid is still captured.

Test Plan:
- Reset, then start_rec and 5 note_valid pulses with note_in = 0,1,2,3,4, then stop -> note_RAM[0..4] = 0..4, i_note = 5, full = 0, state = IDLE.
- start_play -> write_en = 1 on the next cycle and held for 100 cycles; note_valid with note_in = 9 during PLAY -> note_RAM[5] = 0 and i_note = 5 unchanged; stop -> write_en = 0.
- start_rec then 41 note_valid pulses with note_in = k (k = 0..40) -> i_note = 40, full = 1, note_RAM[39] = 39; the 41st note (40) is dropped.
- After reset, start_play with no recording -> state stays IDLE, write_en = 0; start_rec and start_play in the same cycle -> state = RECORD.
- In RECORD with i_note = 3, assert stop and note_valid (note_in = 17) together -> note_RAM[3] = 17, i_note = 4, state = IDLE.
- In PLAY, assert reset mid-cycle -> write_en, i_note, full and all note_RAM entries = 0 immediately; state = IDLE; new start_rec resumes normal recording.
